mem_ctrl_mp: RTL and testbench

- Multi-channel, parametrised successor to the two-client cache memory controller.
- One single-port-per-direction RAM array: one read and one write per cycle.
- Read and write channels are arbitrated separately, using per-request 2-bit priority with round-robin among equal priorities.
- Configurable read latency; byte-strobed writes on all channels.
- Sits between the cache (lookup, fetch, writeback) clients and the backing array.

---
 rtl/mem_ctrl_mp.sv | 203 ++++++++++++++++++++
 tb/tb_mem_ctrl_mp.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_mp.sv
// Multi-channel RAM controller: independent priority/round-robin read and write arbiters.
// Optional MEM_CTRL_MP_BYPASS_EN forwards same-cycle write bytes into the read.
module mem_ctrl_mp #(
   parameter int MEM_DEPTH  = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_CH     = 2,
   parameter int RD_LAT     = 1
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NUM_CH*$clog2(MEM_DEPTH)-1:0]     rd_addr,
   input  logic [NUM_CH-1:0]                       rd_en,
   input  logic [NUM_CH*2-1:0]                     rd_pri,
   output logic [NUM_CH-1:0]                       rd_ready,
   output logic [NUM_CH*DATA_WIDTH-1:0]            rd_data,
   output logic [NUM_CH-1:0]                       rd_valid,
   input  logic [NUM_CH*$clog2(MEM_DEPTH)-1:0]     wr_addr,
   input  logic [NUM_CH-1:0]                       wr_en,
   input  logic [NUM_CH*2-1:0]                     wr_pri,
   input  logic [NUM_CH*DATA_WIDTH/8-1:0]          wr_strb,
   input  logic [NUM_CH*DATA_WIDTH-1:0]            wr_data,
   output logic [NUM_CH-1:0]                       wr_ready
);

   localparam int AW = $clog2(MEM_DEPTH);
   localparam int DW = DATA_WIDTH;
   localparam int SW = DW / 8;
   localparam int PW = $clog2(NUM_CH);

   // Highest priority wins; ties go to the first requester after ptr.
   function automatic logic [NUM_CH-1:0] arb(
      input logic [NUM_CH-1:0]   en,
      input logic [NUM_CH*2-1:0] pri,
      input logic [PW-1:0]       ptr
   );
      logic [1:0]        maxp;
      logic [NUM_CH-1:0] cand;
      logic [NUM_CH-1:0] g;
      logic              found;
      maxp  = '0;
      cand  = '0;
      g     = '0;
      found = 1'b0;
      for (int j = 0; j < NUM_CH; j++) begin
         if (en[j] && pri[2*j +: 2] > maxp) maxp = pri[2*j +: 2];
      end
      for (int j = 0; j < NUM_CH; j++) begin
         cand[j] = en[j] && (pri[2*j +: 2] == maxp);
      end
      for (int j = 0; j < NUM_CH; j++) begin
         if (!found && cand[j] && PW'(j) > ptr) begin
            g[j]  = 1'b1;
            found = 1'b1;
         end
      end
      for (int j = 0; j < NUM_CH; j++) begin
         if (!found && cand[j] && PW'(j) <= ptr) begin
            g[j]  = 1'b1;
            found = 1'b1;
         end
      end
      return g;
   endfunction

   function automatic logic [PW-1:0] to_idx(input logic [NUM_CH-1:0] g);
      logic [PW-1:0] idx;
      idx = '0;
      for (int j = 0; j < NUM_CH; j++) begin
         if (g[j]) idx = PW'(j);
      end
      return idx;
   endfunction

   logic [DW-1:0] mem [MEM_DEPTH];

   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [NUM_CH-1:0]     rd_gnt, wr_gnt;
   logic [PW-1:0]         rd_idx, wr_idx;
   logic                  rd_fire, wr_fire;
   logic [AW-1:0]         raddr, waddr;
   logic [DW-1:0]         wdata;
   logic [SW-1:0]         wstrb;
   logic [DW-1:0]         rd_word;
   logic                  ret_vld;
   logic [PW-1:0]         ret_tag;
   logic [DW-1:0]         ret_dat;
   logic [NUM_CH-1:0]     rd_valid_q, rd_valid_d;
   logic [NUM_CH*DW-1:0]  rd_data_q, rd_data_d;

   always_comb begin
      rd_gnt   = rst ? '0 : arb(rd_en, rd_pri, rd_ptr_q);
      wr_gnt   = rst ? '0 : arb(wr_en, wr_pri, wr_ptr_q);
      rd_idx   = to_idx(rd_gnt);
      wr_idx   = to_idx(wr_gnt);
      rd_fire  = |rd_gnt;
      wr_fire  = |wr_gnt;
      rd_ptr_d = rd_fire ? rd_idx : rd_ptr_q;
      wr_ptr_d = wr_fire ? wr_idx : wr_ptr_q;
   end

   always_comb begin
      raddr = '0;
      waddr = '0;
      wdata = '0;
      wstrb = '0;
      for (int j = 0; j < NUM_CH; j++) begin
         if (rd_gnt[j]) raddr = rd_addr[j*AW +: AW];
         if (wr_gnt[j]) begin
            waddr = wr_addr[j*AW +: AW];
            wdata = wr_data[j*DW +: DW];
            wstrb = wr_strb[j*SW +: SW];
         end
      end
   end

`ifdef MEM_CTRL_MP_BYPASS_EN
   always_comb begin
      rd_word = mem[raddr];
      for (int b = 0; b < SW; b++) begin
         if (wr_fire && waddr == raddr && wstrb[b]) begin
            rd_word[8*b +: 8] = wdata[8*b +: 8];
         end
      end
   end
`else
   assign rd_word = mem[raddr];
`endif

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int b = 0; b < SW; b++) begin
            if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // Extra stage captures data at the grant edge, so later writes cannot disturb it.
   generate
      if (RD_LAT == 2) begin : g_lat2
         logic          s1_vld_q, s1_vld_d;
         logic [PW-1:0] s1_tag_q, s1_tag_d;
         logic [DW-1:0] s1_dat_q, s1_dat_d;

         always_comb begin
            s1_vld_d = rd_fire;
            s1_tag_d = rd_fire ? rd_idx : s1_tag_q;
            s1_dat_d = rd_fire ? rd_word : s1_dat_q;
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               s1_vld_q <= 1'b0;
               s1_tag_q <= '0;
               s1_dat_q <= '0;
            end else begin
               s1_vld_q <= s1_vld_d;
               s1_tag_q <= s1_tag_d;
               s1_dat_q <= s1_dat_d;
            end
         end

         assign ret_vld = s1_vld_q;
         assign ret_tag = s1_tag_q;
         assign ret_dat = s1_dat_q;
      end else begin : g_lat1
         assign ret_vld = rd_fire;
         assign ret_tag = rd_idx;
         assign ret_dat = rd_word;
      end
   endgenerate

   always_comb begin
      rd_valid_d = '0;
      rd_data_d  = rd_data_q;
      for (int j = 0; j < NUM_CH; j++) begin
         if (ret_vld && ret_tag == PW'(j)) begin
            rd_valid_d[j]          = 1'b1;
            rd_data_d[j*DW +: DW]  = ret_dat;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= '0;
         rd_data_q  <= '0;
         rd_ptr_q   <= PW'(NUM_CH - 1);
         wr_ptr_q   <= PW'(NUM_CH - 1);
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   assign rd_ready = rd_gnt;
   assign wr_ready = wr_gnt;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_mem_ctrl_mp.sv
// Directed bench for mem_ctrl_mp: 4 channels, two-cycle read latency.
module tb_mem_ctrl_mp;

   localparam int NCH = 4;
   localparam int AW  = 5;
   localparam int DW  = 32;

   logic                clk;
   logic                rst;
   logic [NCH*AW-1:0]   rd_addr;
   logic [NCH-1:0]      rd_en;
   logic [NCH*2-1:0]    rd_pri;
   logic [NCH-1:0]      rd_ready;
   logic [NCH*DW-1:0]   rd_data;
   logic [NCH-1:0]      rd_valid;
   logic [NCH*AW-1:0]   wr_addr;
   logic [NCH-1:0]      wr_en;
   logic [NCH*2-1:0]    wr_pri;
   logic [NCH*DW/8-1:0] wr_strb;
   logic [NCH*DW-1:0]   wr_data;
   logic [NCH-1:0]      wr_ready;

   int checks   = 0;
   int failures = 0;

   mem_ctrl_mp #(
      .MEM_DEPTH(32),
      .DATA_WIDTH(DW),
      .NUM_CH(NCH),
      .RD_LAT(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rd_addr(rd_addr),
      .rd_en(rd_en),
      .rd_pri(rd_pri),
      .rd_ready(rd_ready),
      .rd_data(rd_data),
      .rd_valid(rd_valid),
      .wr_addr(wr_addr),
      .wr_en(wr_en),
      .wr_pri(wr_pri),
      .wr_strb(wr_strb),
      .wr_data(wr_data),
      .wr_ready(wr_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rd_en = '0;
      wr_en = '0;
   endtask

   task automatic rd_req(input int ch, input logic [4:0] a,
                         input logic [1:0] p);
      rd_en[ch]         = 1'b1;
      rd_addr[ch*AW+:AW] = a;
      rd_pri[ch*2+:2]   = p;
   endtask

   task automatic wr_req(input int ch, input logic [4:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic [1:0] p);
      wr_en[ch]          = 1'b1;
      wr_addr[ch*AW+:AW] = a;
      wr_data[ch*DW+:DW] = d;
      wr_strb[ch*4+:4]   = s;
      wr_pri[ch*2+:2]    = p;
   endtask

   function automatic logic [31:0] dch(input int ch);
      return rd_data[ch*DW+:DW];
   endfunction

   logic [31:0] coll_exp;
   logic [4:0]  a5;

   initial begin
`ifdef MEM_CTRL_MP_BYPASS_EN
      coll_exp = 32'h0000_BEEF;
`else
      coll_exp = 32'h0000_0000;
`endif
      rst     = 1'b1;
      rd_addr = '0;
      rd_en   = '0;
      rd_pri  = '0;
      wr_addr = '0;
      wr_en   = '0;
      wr_pri  = '0;
      wr_strb = '0;
      wr_data = '0;
      tick();
      tick();
      // Requests during reset get no grant.
      rd_req(0, 5'd1, 2'd0);
      wr_req(0, 5'd1, 32'h1, 4'hF, 2'd0);
      #1;
      chk("rst_rd_ready", 128'(rd_ready), 128'h0);
      chk("rst_wr_ready", 128'(wr_ready), 128'h0);
      idle();
      tick();
      rst = 1'b0;
      chk("rst_rd_valid", 128'(rd_valid), 128'h0);
      chk("rst_rd_data", rd_data, 128'h0);

      // Basic write then read on another channel.
      wr_req(0, 5'd5, 32'hA5A5_1234, 4'hF, 2'd0);
      #1;
      chk("basic_wr_ready", 128'(wr_ready), 128'h1);
      tick();
      idle();
      rd_req(1, 5'd5, 2'd0);
      #1;
      chk("basic_rd_ready", 128'(rd_ready), 128'h2);
      tick();
      idle();
      chk("basic_gap", 128'(rd_valid), 128'h0);
      tick();
      chk("basic_valid", 128'(rd_valid), 128'h2);
      chk("basic_data", 128'(dch(1)), 128'hA5A5_1234);
      tick();
      chk("basic_pulse", 128'(rd_valid), 128'h0);

      // Preload 0..15, then stream reads while overwriting the previous address.
      for (int a = 0; a < 16; a++) begin
         a5 = 5'(a);
         wr_req(0, a5, 32'hC0DE_0000 | 32'(a), 4'hF, 2'd0);
         tick();
         idle();
      end
      for (int k = 0; k < 18; k++) begin
         idle();
         if (k < 16) rd_req(3, 5'(k), 2'd0);
         if (k >= 1 && k <= 16)
            wr_req(2, 5'(k - 1), 32'hBAD0_0000 | 32'(k - 1), 4'hF, 2'd0);
         #1;
         if (k < 16) chk("stream_ready", 128'(rd_ready), 128'h8);
         tick();
         if (k >= 1 && k <= 16) begin
            chk("stream_valid", 128'(rd_valid), 128'h8);
            chk("stream_data", 128'(dch(3)), 128'(32'hC0DE_0000 | 32'(k - 1)));
         end else begin
            chk("stream_idle", 128'(rd_valid), 128'h0);
         end
      end
      idle();

      // Byte strobes.
      wr_req(2, 5'd3, 32'h1111_1111, 4'hF, 2'd0);
      tick();
      wr_req(2, 5'd3, 32'hFFEE_DDCC, 4'b0101, 2'd0);
      tick();
      idle();
      rd_req(0, 5'd3, 2'd0);
      tick();
      idle();
      tick();
      chk("strb_valid", 128'(rd_valid), 128'h1);
      chk("strb_data", 128'(dch(0)), 128'h11EE_11CC);

      // Write priority, then same-address collision.
      wr_req(0, 5'd8, 32'h0, 4'hF, 2'd1);
      wr_req(1, 5'd7, 32'h0, 4'hF, 2'd2);
      #1;
      chk("wr_pri_ready", 128'(wr_ready), 128'h2);
      tick();
      idle();
      wr_req(3, 5'd7, 32'hDEAD_BEEF, 4'b0011, 2'd0);
      rd_req(2, 5'd7, 2'd0);
      #1;
      chk("coll_wr_ready", 128'(wr_ready), 128'h8);
      chk("coll_rd_ready", 128'(rd_ready), 128'h4);
      tick();
      idle();
      tick();
      chk("coll_valid", 128'(rd_valid), 128'h4);
      chk("coll_data", 128'(dch(2)), 128'(coll_exp));
      rd_req(2, 5'd7, 2'd0);
      tick();
      idle();
      tick();
      chk("coll_after", 128'(dch(2)), 128'h0000_BEEF);

      // Reset with a read in flight.
      rd_req(1, 5'd5, 2'd0);
      tick();
      idle();
      rst = 1'b1;
      rd_req(2, 5'd3, 2'd0);
      #1;
      chk("mid_rst_ready", 128'(rd_ready), 128'h0);
      tick();
      rst = 1'b0;
      idle();
      chk("mid_rst_valid0", 128'(rd_valid), 128'h0);
      chk("mid_rst_data0", rd_data, 128'h0);
      tick();
      chk("mid_rst_valid1", 128'(rd_valid), 128'h0);
      tick();
      chk("mid_rst_valid2", 128'(rd_valid), 128'h0);
      chk("mid_rst_data2", rd_data, 128'h0);

      // Round robin from reset pointer, then a high-priority channel.
      for (int i = 0; i < NCH; i++) rd_req(i, 5'(16 + i), 2'd0);
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("rr_grant", 128'(rd_ready), 128'(4'b0001 << (k % 4)));
         tick();
      end
      rd_pri[5:4] = 2'd3;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("pri_grant", 128'(rd_ready), 128'h4);
         tick();
      end
      idle();
      tick();
      tick();

      // Array survives reset.
      rd_req(1, 5'd7, 2'd0);
      tick();
      idle();
      tick();
      chk("keep_valid", 128'(rd_valid), 128'h2);
      chk("keep_data7", 128'(dch(1)), 128'h0000_BEEF);
      rd_req(0, 5'd3, 2'd0);
      tick();
      idle();
      tick();
      chk("keep_data3", 128'(dch(0)), 128'h11EE_11CC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
